stopwatch_ctrl: RTL and testbench

//  Front-panel controller for the stopwatch BCD counter. Debounces two raw push-buttons and runs a

---
 rtl/stopwatch_ctrl.sv | 157 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: debounces start/stop and lap/reset buttons,
// sequences IDLE/RUN/PAUSED/LAP and selects live or lap-frozen display digits.
module stopwatch_ctrl #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] sw_d5,
    input  logic [3:0] sw_d4,
    input  logic [3:0] sw_d3,
    input  logic [3:0] sw_d2,
    input  logic [3:0] sw_d1,
    input  logic [3:0] sw_d0,
    output logic       go,
    output logic       clr,
    output logic [3:0] disp_d5,
    output logic [3:0] disp_d4,
    output logic [3:0] disp_d3,
    output logic [3:0] disp_d2,
    output logic [3:0] disp_d1,
    output logic [3:0] disp_d0,
    output logic [1:0] state
);

    localparam int            CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_LAP    = 2'd3;

    logic [1:0]  btn_raw;
    logic [1:0]  press;
    logic [23:0] sw_bus;
    logic [23:0] disp_bus;

    logic [1:0]  state_reg, state_next;
    logic        clr_reg, clr_next;
    logic        post_rst_reg;
    logic        snap_we;

    assign btn_raw = {btn_lr, btn_ss};
    assign sw_bus  = {sw_d5, sw_d4, sw_d3, sw_d2, sw_d1, sw_d0};

    // Per button: 2-FF synchronizer, then a level that only moves after the
    // synchronized input has disagreed with it on DB_CYCLES+1 consecutive edges.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_db
            logic          sync1_reg, sync2_reg;
            logic          level_reg, level_next;
            logic          press_reg, press_next;
            logic [CW-1:0] cnt_reg, cnt_next;

            always_comb begin
                cnt_next   = '0;
                level_next = level_reg;
                press_next = 1'b0;
                if (sync2_reg != level_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        level_next = sync2_reg;
                        press_next = sync2_reg;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    level_reg <= level_next;
                    press_reg <= press_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    // Start/stop always takes priority; a coincident lap/reset press is dropped.
    always_comb begin
        state_next = state_reg;
        clr_next   = 1'b0;
        snap_we    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (press[0])      state_next = ST_RUN;
                else if (press[1]) clr_next   = 1'b1;
            end
            ST_RUN: begin
                if (press[0]) begin
                    state_next = ST_PAUSED;
                end else if (press[1]) begin
                    state_next = ST_LAP;
                    snap_we    = 1'b1;
                end
            end
            ST_LAP: begin
                if (press[0])      state_next = ST_PAUSED;
                else if (press[1]) state_next = ST_RUN;
            end
            ST_PAUSED: begin
                if (press[0]) begin
                    state_next = ST_RUN;
                end else if (press[1]) begin
                    state_next = ST_IDLE;
                    clr_next   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // clr stays high one extra cycle after reset so the counter is always cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            clr_reg      <= 1'b1;
            post_rst_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            clr_reg      <= clr_next | post_rst_reg;
            post_rst_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_dig
            logic [3:0] snap_reg;

            always_ff @(posedge clk) begin
                if (reset)        snap_reg <= 4'd0;
                else if (snap_we) snap_reg <= sw_bus[gi*4 +: 4];
            end

            assign disp_bus[gi*4 +: 4] = (state_reg == ST_LAP) ? snap_reg : sw_bus[gi*4 +: 4];
        end
    endgenerate

    assign go    = (state_reg == ST_RUN) || (state_reg == ST_LAP);
    assign clr   = clr_reg;
    assign state = state_reg;

    assign {disp_d5, disp_d4, disp_d3, disp_d2, disp_d1, disp_d0} = disp_bus;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed panel scenarios plus random button/digit
// traffic, checked every cycle against a window-based behavioural model.
module tb_stopwatch_ctrl;

    localparam int DB   = 4;
    localparam int MAXC = 32768;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_lr = 1'b0;
    logic [23:0] sw_bus = 24'h0;

    logic       go, clr;
    logic [3:0] dd5, dd4, dd3, dd2, dd1, dd0;
    logic [1:0] state;

    stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_ss  (btn_ss),
        .btn_lr  (btn_lr),
        .sw_d5   (sw_bus[23:20]),
        .sw_d4   (sw_bus[19:16]),
        .sw_d3   (sw_bus[15:12]),
        .sw_d2   (sw_bus[11:8]),
        .sw_d1   (sw_bus[7:4]),
        .sw_d0   (sw_bus[3:0]),
        .go      (go),
        .clr     (clr),
        .disp_d5 (dd5),
        .disp_d4 (dd4),
        .disp_d3 (dd3),
        .disp_d2 (dd2),
        .disp_d1 (dd1),
        .disp_d0 (dd0),
        .state   (state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. A press is recognised at edge e when the raw samples
    // taken at edges e-2-DB .. e-2 all disagree with the current debounced level;
    // the pulse it creates is acted on by the state machine at edge e+1.
    bit          hss [MAXC];
    bit          hlr [MAXC];
    int          e = 0;
    logic [1:0]  m_state = 2'd0;
    logic [23:0] m_snap  = 24'h0;
    bit          m_clr   = 1'b0;
    bit          m_post  = 1'b0;
    bit [1:0]    m_lvl   = 2'b00;
    bit [1:0]    m_pulse = 2'b00;
    bit          m_valid = 1'b0;
    bit          m_fclr;
    bit          m_stb;
    bit          m_h;

    always @(posedge clk) begin
        if (e < MAXC) begin
            hss[e] = btn_ss;
            hlr[e] = btn_lr;
            if (reset) begin
                m_state = 2'd0;
                m_snap  = 24'h0;
                m_clr   = 1'b1;
                m_post  = 1'b1;
                m_lvl   = 2'b00;
                m_pulse = 2'b00;
                hss[e]  = 1'b0;
                hlr[e]  = 1'b0;
                if (e > 0) begin
                    hss[e-1] = 1'b0;
                    hlr[e-1] = 1'b0;
                end
                m_valid = 1'b1;
            end else if (m_valid) begin
                m_fclr = 1'b0;
                if (m_pulse[0]) begin
                    case (m_state)
                        2'd0:    m_state = 2'd1;
                        2'd1:    m_state = 2'd2;
                        2'd2:    m_state = 2'd1;
                        default: m_state = 2'd2;
                    endcase
                end else if (m_pulse[1]) begin
                    case (m_state)
                        2'd0: m_fclr = 1'b1;
                        2'd1: begin m_state = 2'd3; m_snap = sw_bus; end
                        2'd2: begin m_state = 2'd0; m_fclr = 1'b1; end
                        default: m_state = 2'd1;
                    endcase
                end
                m_clr  = m_post | m_fclr;
                m_post = 1'b0;
                for (int b = 0; b < 2; b++) begin
                    m_stb = (e >= DB + 2);
                    if (m_stb) begin
                        for (int k = e - 2 - DB; k <= e - 2; k++) begin
                            m_h = (b == 0) ? hss[k] : hlr[k];
                            if (m_h == m_lvl[b]) m_stb = 1'b0;
                        end
                    end
                    if (m_stb) begin
                        m_lvl[b]   = ~m_lvl[b];
                        m_pulse[b] = m_lvl[b];
                    end else begin
                        m_pulse[b] = 1'b0;
                    end
                end
            end
            e++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("state", {30'd0, state}, {30'd0, m_state});
            check("go", {31'd0, go}, {31'd0, (m_state == 2'd1) || (m_state == 2'd3)});
            check("clr", {31'd0, clr}, {31'd0, m_clr});
            check("disp", {8'd0, dd5, dd4, dd3, dd2, dd1, dd0},
                  {8'd0, (m_state == 2'd3) ? m_snap : sw_bus});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press_btn(input bit ss, input bit lr, input int hold, input int rel);
        btn_ss = ss;
        btn_lr = lr;
        step(hold);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        step(rel);
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v;
        for (int i = 0; i < 6; i++) v[i*4 +: 4] = 4'($urandom_range(9));
        return v;
    endfunction

    initial begin
        // Power-up reset, three cycles
        step(3);
        reset = 1'b0;
        step(4);
        check("t1_state", {30'd0, state}, 32'd0);
        check("t1_clr", {31'd0, clr}, 32'd0);

        // Bouncing start/stop, then a long stable hold
        for (int i = 0; i < 5; i++) begin
            btn_ss = 1'b1; step(2);
            btn_ss = 1'b0; step(2);
        end
        btn_ss = 1'b1;
        step(30);
        check("t2_state", {30'd0, state}, 32'd1);
        check("t2_go", {31'd0, go}, 32'd1);
        btn_ss = 1'b0;
        step(12);

        // Lap snapshot freezes while live digits move
        sw_bus = 24'h543210;
        step(2);
        press_btn(1'b0, 1'b1, 10, 2);
        for (int i = 0; i < 8; i++) begin
            sw_bus[3:0] = 4'(i + 1);
            step(1);
        end
        check("t3_snap", {8'd0, dd5, dd4, dd3, dd2, dd1, dd0}, 32'h543210);
        check("t3_state", {30'd0, state}, 32'd3);
        press_btn(1'b0, 1'b1, 10, 10);
        check("t3_back", {30'd0, state}, 32'd1);

        // Pause, reset to idle, idle clear
        press_btn(1'b1, 1'b0, 10, 10);
        check("t4_paused", {30'd0, state}, 32'd2);
        press_btn(1'b0, 1'b1, 10, 10);
        check("t4_idle", {30'd0, state}, 32'd0);
        press_btn(1'b0, 1'b1, 10, 10);

        // Simultaneous presses while running
        press_btn(1'b1, 1'b0, 10, 10);
        sw_bus = 24'h987654;
        press_btn(1'b1, 1'b1, 10, 10);
        check("t5_state", {30'd0, state}, 32'd2);

        // Reset pulse while in LAP
        press_btn(1'b1, 1'b0, 10, 10);
        press_btn(1'b0, 1'b1, 10, 4);
        check("t6_lap", {30'd0, state}, 32'd3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(3);
        check("t6_idle", {30'd0, state}, 32'd0);

        // Random traffic: bounces, holds, digit changes and occasional resets
        while (e < 12000) begin
            if ($urandom_range(99) < 3) begin
                reset = 1'b1;
                step($urandom_range(1, 3));
                reset = 1'b0;
            end else begin
                if ($urandom_range(2) == 0) btn_ss = ~btn_ss;
                if ($urandom_range(2) == 0) btn_lr = ~btn_lr;
                if ($urandom_range(1) == 0) sw_bus = rand_bcd();
                step($urandom_range(1, 14));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
